keyseq_recorder_ctrl: RTL
=========================

// Module: keyseq_recorder_ctrl
// PURPOSE
//  Record/playback sequencer for the synth's 4-key switch bank. RECORD run-length-encodes key
//  states into an internal RAM on a slow tick. PLAY replays them to keys_out, which feeds the
//  sound block. mode drives the GUI status display. Sits between switch inputs and sound/gui.
// PARAMETERS
//  TICK_DIV  500000  clock cycles per time tick (10 ms @ 50 MHz)
//  DEPTH     256     RAM entries
//  ADDR_W    8       log2(DEPTH)
//  DUR_W     8       duration field width; max run = 2^DUR_W-1 ticks
// PORTS
//  clock     in   1        system clock (CLOCK_50)
//  reset     in   1        synchronous, active-high
//  go        in   1        1-cycle pulse (edge-detected upstream): start/stop record
//  play      in   1        1-cycle pulse: start/abort playback
//  keys_in   in   4        live key state
//  keys_out  out  4        registered key state to sound block
//  mode      out  2        00 idle, 01 record, 10 play
//  count     out  ADDR_W+1 stored entries
//  full      out  1        last recording hit DEPTH
// BEHAVIOUR
//  Reset: state IDLE, keys_out=0, mode=00, count=0, full=0, tick ctr=0, ptrs=0. Reset
//   mid-record/play aborts at once; stored recording discarded (count=0).
//  Tick: ctr 0..TICK_DIV-1, tick=1 for one cycle at TICK_DIV-1. Ctr cleared on entry to
//   RECORD or LOAD-from-IDLE; holds 0 in IDLE.
//  Entry = {keys[3:0], dur[DUR_W-1:0]}. RAM: single port, synchronous read, 1-cycle latency.
//  IDLE: keys_out<=keys_in (1-cycle latency). go -> RECORD: wr_ptr=0, full=0, cur=keys_in,
//   run=0. play with count!=0 -> LOAD (rd_ptr=0). play with count==0 ignored.
//   go and play same cycle: go wins.
//  RECORD: keys_out<=keys_in. On tick:
//   keys_in==cur and run<MAX -> run++.
//   Otherwise -> write {cur,run} at wr_ptr if run!=0, wr_ptr++, cur<=keys_in, run<=1.
//   A write making wr_ptr==DEPTH -> IDLE, count=DEPTH, full=1.
//   go (or play) -> flush pending {cur,run} if run!=0 and room remains, count<=final wr_ptr,
//   -> IDLE. Flush and tick write in same cycle: tick write only, then go handled next cycle.
//  LOAD: issue read rd_ptr; next cycle -> PLAY: keys_out<=entry.keys, remain<=entry.dur.
//   keys_out holds previous value during LOAD (no glitch to 0 between entries).
//  PLAY: on tick remain--. remain reaching 0 -> rd_ptr++. rd_ptr+1==count -> IDLE with
//   keys_out=0; else LOAD. play or go in PLAY/LOAD -> IDLE, keys_out=0 (go does not also
//   start a recording). Recording survives playback; count unchanged.
//  mode: 01 in RECORD, 10 in LOAD/PLAY, else 00; registered with state.
//  Widths: run saturates at 2^DUR_W-1, never wraps. count is ADDR_W+1 bits so DEPTH fits.
// STRUCTURE
//  synth_pkg: MODE_IDLE/MODE_REC/MODE_PLAY encodings, KEY_W=4, state enum.
//  Sub-module rec_ram: DEPTH x (4+DUR_W) synchronous single-port RAM (inferred).
//  FSM, tick divider and RLE logic stay in this module.
// TESTING (sim with TICK_DIV=4, DEPTH=4, DUR_W=8)
//  1 Reset asserted mid-RECORD -> next cycle mode=00, keys_out=0, count=0, full=0.
//  2 go; keys=0001 for 3 ticks, 0100 for 2 ticks; go -> count=2, RAM[0]={1,3}, RAM[1]={4,2}.
//  3 play after 2 -> mode=10; keys_out=0001 for 12 cycles, then 0100 for 8 (+LOAD cycle
//    between), then keys_out=0000, mode=00.
//  4 Hold keys=0010 for 300 ticks, go -> entries {2,255},{2,45}, count=2.
//  5 Change keys every tick after go -> after 4th write mode=00, full=1, count=4; further
//    ticks write nothing.
//  6 play with count=0 -> stays IDLE; go+play same cycle -> RECORD; play during PLAY ->
//    IDLE, keys_out=0, count preserved.

Source files
------------

// File: rtl/keyseq_recorder_ctrl_pkg.sv
// Shared types for the key-sequence recorder: mode encodings, key width, controller states.
// Pure declarations; no latency and no flow control.
package keyseq_recorder_ctrl_pkg;

   localparam int KEY_W = 4;

   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_REC  = 2'b01;
   localparam logic [1:0] MODE_PLAY = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECORD,
      ST_LOAD,
      ST_PLAY
   } state_e;

   function automatic logic [1:0] mode_of(state_e st);
      logic [1:0] m;
      m = MODE_IDLE;
      case (st)
         ST_RECORD:        m = MODE_REC;
         ST_LOAD, ST_PLAY: m = MODE_PLAY;
         default:          m = MODE_IDLE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/keyseq_recorder_ctrl_rec_ram.sv
// Single-port recording RAM, read-before-write; rd_dat is valid 1 cycle after addr.
// No backpressure: one access per cycle, caller arbitrates the port.
module keyseq_recorder_ctrl_rec_ram #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 12
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_dat,
   output logic [DATA_W-1:0] rd_dat
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_dat_q;

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wr_dat;
      end
      rd_dat_q <= mem[addr];
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/keyseq_recorder_ctrl.sv
// Record/playback sequencer: run-length encodes the key bank per tick, replays it to keys_out.
// keys_out is registered (1 cycle); no backpressure, go/play are single-cycle pulses.
module keyseq_recorder_ctrl
   import keyseq_recorder_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 500000,
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 8,
   parameter int DUR_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic             play,
   input  logic [KEY_W-1:0] keys_in,
   output logic [KEY_W-1:0] keys_out,
   output logic [1:0]       mode,
   output logic [ADDR_W:0]  count,
   output logic             full
);

   localparam int CTR_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PTR_W = ADDR_W + 1;
   localparam int ENT_W = KEY_W + DUR_W;

   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TICK_DIV - 1);
   localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
   localparam logic [DUR_W-1:0] RUN_MAX  = '1;
   localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

   state_e           st_q, st_d;
   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] count_q, count_d;
   logic [KEY_W-1:0] cur_q, cur_d;
   logic [KEY_W-1:0] keys_out_q, keys_out_d;
   logic [DUR_W-1:0] run_q, run_d;
   logic [DUR_W-1:0] remain_q, remain_d;
   logic             full_q, full_d;
   logic             stop_pend_q, stop_pend_d;
   logic [1:0]       mode_q, mode_d;

   logic              tick;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [ENT_W-1:0]  ram_wdat;
   logic [ENT_W-1:0]  ram_rdat;

   always_comb begin
      st_d        = st_q;
      ctr_d       = ctr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      cur_d       = cur_q;
      run_d       = run_q;
      remain_d    = remain_q;
      keys_out_d  = keys_out_q;
      full_d      = full_q;
      stop_pend_d = 1'b0;
      ram_we      = 1'b0;
      ram_wdat    = {cur_q, run_q};
      tick        = (ctr_q == CTR_LAST);

      case (st_q)
         ST_IDLE: begin
            ctr_d      = '0;
            keys_out_d = keys_in;
            if (go) begin
               st_d     = ST_RECORD;
               wr_ptr_d = '0;
               count_d  = '0;
               full_d   = 1'b0;
               cur_d    = keys_in;
               run_d    = '0;
            end else if (play && (count_q != '0)) begin
               st_d     = ST_LOAD;
               rd_ptr_d = '0;
            end
         end

         ST_RECORD: begin
            keys_out_d = keys_in;
            ctr_d      = tick ? '0 : ctr_q + CTR_ONE;
            if (tick) begin
               // The RAM port belongs to the tick this cycle; a stop is flushed next cycle.
               stop_pend_d = go | play;
               if ((keys_in == cur_q) && (run_q != RUN_MAX)) begin
                  run_d = run_q + DUR_ONE;
               end else begin
                  if (run_q != '0) begin
                     ram_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + PTR_ONE;
                     if (wr_ptr_d == DEPTH_C) begin
                        st_d        = ST_IDLE;
                        count_d     = DEPTH_C;
                        full_d      = 1'b1;
                        stop_pend_d = 1'b0;
                     end
                  end
                  cur_d = keys_in;
                  run_d = DUR_ONE;
               end
            end else if (go || play || stop_pend_q) begin
               if (run_q != '0) begin
                  ram_we  = 1'b1;
                  count_d = wr_ptr_q + PTR_ONE;
               end else begin
                  count_d = wr_ptr_q;
               end
               full_d = (count_d == DEPTH_C);
               st_d   = ST_IDLE;
            end
         end

         // The read was launched with rd_ptr_d on the way in, so the entry is on ram_rdat here.
         // The tick counter is frozen so every entry plays for exactly dur * TICK_DIV cycles.
         ST_LOAD: begin
            if (go || play) begin
               st_d       = ST_IDLE;
               keys_out_d = '0;
            end else begin
               st_d       = ST_PLAY;
               keys_out_d = ram_rdat[ENT_W-1 -: KEY_W];
               remain_d   = ram_rdat[DUR_W-1:0];
            end
         end

         ST_PLAY: begin
            ctr_d = tick ? '0 : ctr_q + CTR_ONE;
            if (go || play) begin
               st_d       = ST_IDLE;
               keys_out_d = '0;
            end else if (tick) begin
               remain_d = remain_q - DUR_ONE;
               if (remain_q == DUR_ONE) begin
                  if ((rd_ptr_q + PTR_ONE) == count_q) begin
                     st_d       = ST_IDLE;
                     keys_out_d = '0;
                  end else begin
                     rd_ptr_d = rd_ptr_q + PTR_ONE;
                     st_d     = ST_LOAD;
                  end
               end
            end
         end

         default: st_d = ST_IDLE;
      endcase

      mode_d = mode_of(st_d);
   end

   assign ram_addr = ram_we ? wr_ptr_q[ADDR_W-1:0] : rd_ptr_d[ADDR_W-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         st_q        <= ST_IDLE;
         ctr_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cur_q       <= '0;
         run_q       <= '0;
         remain_q    <= '0;
         keys_out_q  <= '0;
         full_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         mode_q      <= MODE_IDLE;
      end else begin
         st_q        <= st_d;
         ctr_q       <= ctr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cur_q       <= cur_d;
         run_q       <= run_d;
         remain_q    <= remain_d;
         keys_out_q  <= keys_out_d;
         full_q      <= full_d;
         stop_pend_q <= stop_pend_d;
         mode_q      <= mode_d;
      end
   end

   keyseq_recorder_ctrl_rec_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (ENT_W)
   ) u_ram (
      .clock  (clock),
      .we     (ram_we),
      .addr   (ram_addr),
      .wr_dat (ram_wdat),
      .rd_dat (ram_rdat)
   );

   assign keys_out = keys_out_q;
   assign mode     = mode_q;
   assign count    = count_q;
   assign full     = full_q;

endmodule
